memory_master_32: RTL and testbench
===================================

MEMORY_MASTER_32 -- requirements
Module: memory_master_32

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of cycles to wait for bus_acknowledge before abort (range 1..255, 8-bit counter).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  requester presents a transaction.
REQ-005 cmd_ready  output  1  block can accept a transaction (high only in IDLE).
REQ-006 cmd_rw  input  1  1 = read, 0 = write.
REQ-007 cmd_address  input  16  word address.
REQ-008 cmd_byte_en  input  4  byte lanes.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle pulse, transaction complete.
REQ-011 rsp_rdata  output  32  read data, valid with rsp_valid on reads.
REQ-012 rsp_error  output  1  valid with rsp_valid; 1 = timed out.
REQ-013 bus_address  output  16  word address to responder.
REQ-014 bus_bus_enable  output  1  request valid, held until acknowledge.
REQ-015 bus_byte_enable  output  4  byte lanes to responder.
REQ-016 bus_rw  output  1  1 = read, 0 = write.
REQ-017 bus_write_data  output  32  write data to responder.
REQ-018 bus_acknowledge  input  1  responder completion, one-cycle pulse.
REQ-019 bus_read_data  input  32  read data, valid in the cycle bus_acknowledge is high.

Function
REQ-020 States IDLE, REQ, RECOVER; all outputs registered except cmd_ready = (state == IDLE).
REQ-021 IDLE: on cmd_valid & cmd_ready at an edge, latch cmd_address/cmd_byte_en/cmd_rw/cmd_wdata onto bus_* outputs, set bus_bus_enable, clear timeout counter, go REQ.
REQ-022 REQ: bus_* outputs stable, bus_bus_enable held high until bus_acknowledge sampled high.
REQ-023 REQ, bus_acknowledge high at edge: bus_bus_enable <= 0, rsp_valid <= 1, rsp_error <= 0, rsp_rdata <= bus_read_data if bus_rw = 1 else unchanged, go RECOVER.
REQ-024 RECOVER: rsp_valid <= 0, go IDLE; guarantees at least one cycle with bus_bus_enable low between transactions so the responder cannot double-start.
REQ-025 bus_acknowledge while in IDLE or RECOVER is ignored; no state or output change.
REQ-026 cmd_valid while not in IDLE is ignored (no queuing); requester holds cmd_valid until cmd_ready.
REQ-027 Minimum latency: bus_bus_enable rises 1 cycle after acceptance; rsp_valid rises 1 cycle after the acknowledge cycle; next acceptance no earlier than 2 cycles after acknowledge.
REQ-028 bus_address is the word address; byte addressing is the responder's concern.

Reset
REQ-029 reset high forces state IDLE asynchronously, regardless of current state.
REQ-030 Reset values: bus_bus_enable 0, bus_rw 0, bus_address 0, bus_byte_enable 0, bus_write_data 0, rsp_valid 0, rsp_error 0, rsp_rdata 0, timeout counter 0.
REQ-031 Reset during REQ abandons the transaction with no rsp_valid; a late bus_acknowledge after release is ignored per REQ-025.

Configuration
REQ-032 Macro BUS_TIMEOUT_EN defined: counter increments each REQ cycle without acknowledge; when it reaches TIMEOUT_CYCLES, bus_bus_enable <= 0, rsp_valid <= 1, rsp_error <= 1, rsp_rdata unchanged, go RECOVER.
REQ-033 Acknowledge and timeout at the same edge: acknowledge wins, rsp_error = 0.
REQ-034 BUS_TIMEOUT_EN undefined: no counter logic; REQ waits indefinitely; rsp_error tied 0; TIMEOUT_CYCLES unused.

Verification
REQ-035 Write: cmd rw=0, addr 0x0012, be 0xF, wdata 0xDEADBEEF; responder acks 2 cycles after enable -> bus outputs match during REQ, rsp_valid one cycle after ack, rsp_error 0.
REQ-036 Read: cmd rw=1, addr 0x00FF; responder returns 0xCAFEF00D with ack 3 cycles after enable -> rsp_rdata 0xCAFEF00D, single rsp_valid pulse.
REQ-037 Back-to-back: cmd_valid held high with two commands -> bus_bus_enable low for at least one cycle between them, second accepted in IDLE after RECOVER.
REQ-038 Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack -> bus_bus_enable drops and rsp_valid=1, rsp_error=1 after 8 REQ cycles; ack at cycle 8 instead -> rsp_error=0.
REQ-039 Reset mid-REQ: assert reset 1 cycle after enable rises -> all outputs to reset values immediately, no rsp_valid, later ack ignored.
REQ-040 Spurious ack in IDLE -> no rsp_valid, outputs unchanged.

Source files
------------

// File: rtl/memory_master_32_if.sv
// Requester and responder signals of memory_master_32.
// The master modport is the block's own view; slave is the view of its environment.
interface memory_master_32_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rw;
   logic [15:0] cmd_address;
   logic [3:0]  cmd_byte_en;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [15:0] bus_address;
   logic        bus_bus_enable;
   logic [3:0]  bus_byte_enable;
   logic        bus_rw;
   logic [31:0] bus_write_data;
   logic        bus_acknowledge;
   logic [31:0] bus_read_data;

   modport master (
      input  cmd_valid, cmd_rw, cmd_address, cmd_byte_en, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
      output bus_address, bus_bus_enable, bus_byte_enable, bus_rw, bus_write_data,
      input  bus_acknowledge, bus_read_data
   );

   modport slave (
      output cmd_valid, cmd_rw, cmd_address, cmd_byte_en, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
      input  bus_address, bus_bus_enable, bus_byte_enable, bus_rw, bus_write_data,
      output bus_acknowledge, bus_read_data
   );
endinterface

// File: rtl/memory_master_32.sv
// Single-outstanding 32-bit memory bus master: accepts one command, drives it until acknowledged.
// Optional acknowledge timeout is compiled in with BUS_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// REQ        | bus request held, waiting for acknowledge (or timeout)
// RECOVER    | response pulse cycle; forces a bus_bus_enable low gap
module memory_master_32 #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic           clk,
   input  logic           reset,
   memory_master_32_if.master mm
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("memory_master_32: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        bus_en_q, bus_en_d;
   logic        bus_rw_q, bus_rw_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic        rsp_error_q, rsp_error_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bus_en_q    <= 1'b0;
         bus_rw_q    <= 1'b0;
         bus_addr_q  <= 16'h0000;
         bus_be_q    <= 4'h0;
         bus_wdata_q <= 32'h0000_0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt_q   <= 8'h00;
         rsp_error_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_en_q    <= bus_en_d;
         bus_rw_q    <= bus_rw_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         rsp_error_q <= rsp_error_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      bus_en_d    = bus_en_q;
      bus_rw_d    = bus_rw_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      rsp_error_d = rsp_error_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (mm.cmd_valid) begin
               bus_rw_d    = mm.cmd_rw;
               bus_addr_d  = mm.cmd_address;
               bus_be_d    = mm.cmd_byte_en;
               bus_wdata_d = mm.cmd_wdata;
               bus_en_d    = 1'b1;
`ifdef BUS_TIMEOUT_EN
               tmo_cnt_d   = 8'h00;
`endif
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            // Acknowledge is tested first so it wins over a same-edge timeout.
            if (mm.bus_acknowledge) begin
               bus_en_d    = 1'b0;
               rsp_valid_d = 1'b1;
               if (bus_rw_q) begin
                  rsp_rdata_d = mm.bus_read_data;
               end
`ifdef BUS_TIMEOUT_EN
               rsp_error_d = 1'b0;
`endif
               state_d     = ST_RECOVER;
            end
`ifdef BUS_TIMEOUT_EN
            else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
               if (tmo_cnt_d == TIMEOUT_LIMIT) begin
                  bus_en_d    = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
                  state_d     = ST_RECOVER;
               end
            end
`endif
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mm.cmd_ready       = (state_q == ST_IDLE);
   assign mm.rsp_valid       = rsp_valid_q;
   assign mm.rsp_rdata       = rsp_rdata_q;
   assign mm.bus_bus_enable  = bus_en_q;
   assign mm.bus_rw          = bus_rw_q;
   assign mm.bus_address     = bus_addr_q;
   assign mm.bus_byte_enable = bus_be_q;
   assign mm.bus_write_data  = bus_wdata_q;
`ifdef BUS_TIMEOUT_EN
   assign mm.rsp_error       = rsp_error_q;
`else
   assign mm.rsp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_memory_master_32.sv
// Self-checking bench for memory_master_32: directed cases plus randomized transactions
// compared against a transaction-level model of the expected bus and response values.
module tb_memory_master_32;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   memory_master_32_if intf ();

   memory_master_32 #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .mm    (intf.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: last accepted command and the read data the requester should currently see.
   logic        m_rw;
   logic [15:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag);
      chk({tag, "_en"},    32'(intf.bus_bus_enable), 32'd1);
      chk({tag, "_addr"},  32'(intf.bus_address),    32'(m_addr));
      chk({tag, "_be"},    32'(intf.bus_byte_enable), 32'(m_be));
      chk({tag, "_rw"},    32'(intf.bus_rw),         32'(m_rw));
      chk({tag, "_wdata"}, intf.bus_write_data,      m_wdata);
      chk({tag, "_rspv"},  32'(intf.rsp_valid),      32'd0);
      chk({tag, "_ready"}, 32'(intf.cmd_ready),      32'd0);
   endtask

   // Present a command at a negedge; returns at the first negedge after acceptance.
   task automatic issue(input logic rw, input logic [15:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output int waits);
      intf.cmd_valid   = 1'b1;
      intf.cmd_rw      = rw;
      intf.cmd_address = addr;
      intf.cmd_byte_en = be;
      intf.cmd_wdata   = wdata;
      waits = 0;
      forever begin
         chk("wait_en_low", 32'(intf.bus_bus_enable), 32'd0);
         if (intf.cmd_ready === 1'b1) begin
            chk("idle_rspv_low", 32'(intf.rsp_valid), 32'd0);
            break;
         end
         @(negedge clk);
         waits++;
         if (waits > 20) begin
            $display("FAIL accept_timeout observed=%0d expected<=20", waits);
            $fatal(1, "cmd never accepted");
         end
      end
      @(posedge clk);
      m_rw = rw; m_addr = addr; m_be = be; m_wdata = wdata;
      @(negedge clk);
      intf.cmd_valid   = 1'b0;
      intf.cmd_rw      = 1'($urandom);
      intf.cmd_address = 16'($urandom);
      intf.cmd_wdata   = $urandom;
      chk_bus("req_start");
   endtask

   // Hold REQ for `delay` edges; optionally acknowledge on the last one.
   task automatic run_req(input int delay, input bit do_ack, input logic [31:0] rdata);
      for (int c = 1; c <= delay; c++) begin
         if (c > 1) begin
            @(negedge clk);
            chk_bus("req_hold");
         end
         if (c == delay && do_ack) begin
            intf.bus_acknowledge = 1'b1;
            intf.bus_read_data   = rdata;
         end
      end
      @(negedge clk);
      intf.bus_acknowledge = 1'b0;
      intf.bus_read_data   = $urandom;
   endtask

   task automatic chk_ack_rsp(input string tag, input logic [31:0] rdata);
      if (m_rw) m_rdata = rdata;
      chk({tag, "_rspv"},  32'(intf.rsp_valid),      32'd1);
      chk({tag, "_err"},   32'(intf.rsp_error),      32'd0);
      chk({tag, "_rdata"}, intf.rsp_rdata,           m_rdata);
      chk({tag, "_en"},    32'(intf.bus_bus_enable), 32'd0);
      chk({tag, "_ready"}, 32'(intf.cmd_ready),      32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_en"},    32'(intf.bus_bus_enable), 32'd0);
      chk({tag, "_addr"},  32'(intf.bus_address),    32'd0);
      chk({tag, "_be"},    32'(intf.bus_byte_enable), 32'd0);
      chk({tag, "_rw"},    32'(intf.bus_rw),         32'd0);
      chk({tag, "_wdata"}, intf.bus_write_data,      32'd0);
      chk({tag, "_rspv"},  32'(intf.rsp_valid),      32'd0);
      chk({tag, "_err"},   32'(intf.rsp_error),      32'd0);
      chk({tag, "_rdata"}, intf.rsp_rdata,           32'd0);
      chk({tag, "_ready"}, 32'(intf.cmd_ready),      32'd1);
   endtask

   initial begin
      int          waits;
      logic [31:0] rd;
      checks = 0; failures = 0;
      m_rw = 1'b0; m_addr = 16'h0; m_be = 4'h0; m_wdata = 32'h0; m_rdata = 32'h0;
      intf.cmd_valid = 1'b0; intf.cmd_rw = 1'b0; intf.cmd_address = 16'h0;
      intf.cmd_byte_en = 4'h0; intf.cmd_wdata = 32'h0;
      intf.bus_acknowledge = 1'b0; intf.bus_read_data = 32'h0;
      reset = 1'b1;
      #23;
      chk_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Write, ack 2 cycles after enable
      issue(1'b0, 16'h0012, 4'hF, 32'hDEADBEEF, waits);
      run_req(2, 1'b1, 32'h1111_2222);
      chk_ack_rsp("write", 32'h1111_2222);
      @(negedge clk);
      chk("write_rsp_pulse", 32'(intf.rsp_valid), 32'd0);

      // Read, ack 3 cycles after enable
      issue(1'b1, 16'h00FF, 4'hF, 32'h0, waits);
      run_req(3, 1'b1, 32'hCAFEF00D);
      chk_ack_rsp("read", 32'hCAFEF00D);
      chk("read_data_exact", intf.rsp_rdata, 32'hCAFEF00D);
      @(negedge clk);
      chk("read_rsp_pulse", 32'(intf.rsp_valid), 32'd0);
      chk("read_rdata_hold", intf.rsp_rdata, 32'hCAFEF00D);

      // Back-to-back: second command presented during RECOVER
      issue(1'b0, 16'h0100, 4'h3, 32'h0102_0304, waits);
      run_req(1, 1'b1, 32'h0);
      chk_ack_rsp("b2b_first", 32'h0);
      issue(1'b1, 16'h0101, 4'hC, 32'h0, waits);
      chk("b2b_gap_cycles", 32'(waits), 32'd1);
      run_req(1, 1'b1, 32'h5A5A_A5A5);
      chk_ack_rsp("b2b_second", 32'h5A5A_A5A5);

      // Acknowledge on the timeout edge still completes without error
      issue(1'b1, 16'h0200, 4'h1, 32'h0, waits);
      run_req(8, 1'b1, 32'h8888_0008);
      chk_ack_rsp("ack_at_limit", 32'h8888_0008);

      // No acknowledge
      @(negedge clk);
      issue(1'b0, 16'h0300, 4'hF, 32'h7777_7777, waits);
      run_req(8, 1'b0, 32'h0);
`ifdef BUS_TIMEOUT_EN
      chk("tmo_rspv",  32'(intf.rsp_valid),      32'd1);
      chk("tmo_err",   32'(intf.rsp_error),      32'd1);
      chk("tmo_rdata", intf.rsp_rdata,           m_rdata);
      chk("tmo_en",    32'(intf.bus_bus_enable), 32'd0);
      @(negedge clk);
      chk("tmo_pulse", 32'(intf.rsp_valid),      32'd0);
`else
      chk_bus("no_tmo_hold");
      run_req(12, 1'b1, 32'h0);
      chk_ack_rsp("no_tmo_late_ack", 32'h0);
`endif

      // Spurious acknowledge in IDLE
      @(negedge clk);
      @(negedge clk);
      intf.bus_acknowledge = 1'b1;
      intf.bus_read_data   = 32'hBAD0_BAD0;
      @(negedge clk);
      intf.bus_acknowledge = 1'b0;
      chk("spur_rspv",  32'(intf.rsp_valid),      32'd0);
      chk("spur_en",    32'(intf.bus_bus_enable), 32'd0);
      chk("spur_rdata", intf.rsp_rdata,           m_rdata);
      chk("spur_addr",  32'(intf.bus_address),    32'(m_addr));
      chk("spur_ready", 32'(intf.cmd_ready),      32'd1);

      // Randomized transactions
      for (int i = 0; i < 24; i++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) @(negedge clk);
         rd = $urandom;
         issue(1'($urandom), 16'($urandom), 4'($urandom), $urandom, waits);
         run_req(int'($urandom_range(1, 8)), 1'b1, rd);
         chk_ack_rsp("rand", rd);
      end

      // Reset one cycle into REQ, then a late acknowledge
      @(negedge clk);
      issue(1'b1, 16'h0ABC, 4'hF, 32'h0, waits);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      m_rw = 1'b0; m_addr = 16'h0; m_be = 4'h0; m_wdata = 32'h0; m_rdata = 32'h0;
      chk_reset_outputs("mid_req_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      intf.bus_acknowledge = 1'b1;
      intf.bus_read_data   = 32'hFEED_FACE;
      @(negedge clk);
      intf.bus_acknowledge = 1'b0;
      chk_reset_outputs("late_ack");
      @(negedge clk);
      chk("late_ack_rspv", 32'(intf.rsp_valid), 32'd0);

      // Still functional after reset
      issue(1'b1, 16'h0042, 4'h5, 32'h0, waits);
      run_req(2, 1'b1, 32'h0BAD_CAFE);
      chk_ack_rsp("post_reset", 32'h0BAD_CAFE);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
